multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core: Moore sequencing FSM, ImmSrc decode for the
// immediate extender, branch PC-enable logic and the combinational ALU decoder.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [2:0] ImmSrc,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JALRADR, JAL, LUI
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore output table: everything not named for a state stays 0.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
            DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            MEMADR, EXECI, JALRADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = (s == EXECI) ? 2'b10 : 2'b00;
            end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECR: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            ALUWB:    c.regwrite = 1'b1;
            BRANCH: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
            end
            JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            LUI: begin
                c.resultsrc = 2'b11;
                c.regwrite  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_known(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Only DECODE and MEMADR look at op; every other transition is fixed.
    function automatic state_t next_for(input state_t s, input logic [6:0] o);
        case (s)
            FETCH:  return DECODE;
            DECODE: begin
                case (o)
                    OP_LOAD, OP_STORE: return MEMADR;
                    OP_RTYPE:          return EXECR;
                    OP_ITYPE:          return EXECI;
                    OP_BRANCH:         return BRANCH;
                    OP_JAL:            return JAL;
                    OP_JALR:           return JALRADR;
                    OP_LUI:            return LUI;
                    OP_AUIPC:          return ALUWB;
                    default:           return FETCH;
                endcase
            end
            MEMADR:   return o[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  return MEMWB;
            EXECR:    return ALUWB;
            EXECI:    return ALUWB;
            JALRADR:  return JAL;
            JAL:      return ALUWB;
            default:  return FETCH;
        endcase
    endfunction

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    ctrl_t  fetch_ctrl;
    ctrl_t  eff;

    assign state_nxt  = next_for(state, op);
    assign fetch_ctrl = ctrl_for(FETCH);

    // The output register is loaded with the next state's decode so outputs stay glitch-free.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            state <= FETCH;
            ctrl  <= fetch_ctrl;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_for(state_nxt);
        end
    end

    // While reset is held, present FETCH selects with every write enable suppressed.
    assign eff       = reset_n ? ctrl : fetch_ctrl;
    assign PCWrite   = reset_n & (eff.pcupdate | (eff.branch & (Zero ^ funct3[0])));
    assign IRWrite   = reset_n & eff.irwrite;
    assign RegWrite  = reset_n & eff.regwrite;
    assign MemWrite  = reset_n & eff.memwrite;
    assign AdrSrc    = eff.adrsrc;
    assign ResultSrc = eff.resultsrc;
    assign ALUSrcA   = eff.alusrca;
    assign ALUSrcB   = eff.alusrcb;
    assign Illegal   = reset_n & (state == DECODE) & ~op_known(op);

    always_comb begin
        // NOTE: default first so no path through the case leaves the output unassigned,
        // which would otherwise infer a latch.
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:        ImmSrc = 3'b001;
            OP_BRANCH:       ImmSrc = 3'b010;
            OP_JAL:          ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (eff.aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: per-cycle expected outputs for
// every instruction class, plus hand-written mid-instruction reset sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [2:0] ImmSrc;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ImmSrc(ImmSrc), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] res, sa, sb;
        logic [2:0] alc, imm;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           BAD = 7'b1111111;
    localparam logic [2:0] IM_I = 3'b000, IM_S = 3'b001, IM_B = 3'b010,
                           IM_J = 3'b011, IM_U = 3'b100;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic outs_t o(input logic pcw, adr, mw, irw, rw,
                                input logic [1:0] res, sa, sb,
                                input logic [2:0] alc, imm, input logic ill);
        return '{pcw, adr, mw, irw, rw, res, sa, sb, alc, imm, ill};
    endfunction

    task automatic add(input logic [6:0] op_v, input logic [2:0] f3, input logic f7,
                       input logic z, input outs_t e);
        vec_t v;
        v.op = op_v; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    // FETCH then DECODE rows, common to every instruction.
    task automatic fd(input logic [6:0] op_v, input logic [2:0] f3, input logic f7,
                      input logic z, input logic [2:0] imm, input logic ill);
        add(op_v, f3, f7, z, o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0));
        add(op_v, f3, f7, z, o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill));
    endtask

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got pcw%b adr%b mw%b irw%b rw%b res%b sa%b sb%b alc%b imm%b ill%b, expected pcw%b adr%b mw%b irw%b rw%b res%b sa%b sb%b alc%b imm%b ill%b",
                     name, got.pcw, got.adr, got.mw, got.irw, got.rw, got.res, got.sa,
                     got.sb, got.alc, got.imm, got.ill, exp.pcw, exp.adr, exp.mw, exp.irw,
                     exp.rw, exp.res, exp.sa, exp.sb, exp.alc, exp.imm, exp.ill);
        end
    endtask

    function automatic outs_t sample();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, Illegal};
    endfunction

    // Drive at the negative edge, compare 1 ns later, then wait for the next negative edge.
    task automatic apply(input string name, input vec_t v);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z;
        #1;
        check(name, sample(), v.exp);
        @(negedge clk);
    endtask

    function automatic vec_t mkv(input logic [6:0] op_v, input outs_t e);
        vec_t v;
        v.op = op_v; v.f3 = 3'b000; v.f7 = 1'b0; v.z = 1'b0; v.exp = e;
        return v;
    endfunction

    initial begin
        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        fd(LW, 3'b010, 0, 0, IM_I, 0);
        add(LW, 3'b010, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_I, 0));
        add(LW, 3'b010, 0, 0, o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        add(LW, 3'b010, 0, 0, o(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, IM_I, 0));
        // beq/bne with Zero 1 and 0
        fd(BR, 3'b000, 0, 1, IM_B, 0);
        add(BR, 3'b000, 0, 1, o(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, IM_B, 0));
        fd(BR, 3'b001, 0, 1, IM_B, 0);
        add(BR, 3'b001, 0, 1, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, IM_B, 0));
        fd(BR, 3'b000, 0, 0, IM_B, 0);
        add(BR, 3'b000, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, IM_B, 0));
        fd(BR, 3'b001, 0, 0, IM_B, 0);
        add(BR, 3'b001, 0, 0, o(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, IM_B, 0));
        // R-type sub, and, xor, sll (-> add)
        fd(RT, 3'b000, 1, 0, IM_I, 0);
        add(RT, 3'b000, 1, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, IM_I, 0));
        add(RT, 3'b000, 1, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        fd(RT, 3'b111, 0, 0, IM_I, 0);
        add(RT, 3'b111, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, IM_I, 0));
        add(RT, 3'b111, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        fd(RT, 3'b100, 0, 0, IM_I, 0);
        add(RT, 3'b100, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b100, IM_I, 0));
        add(RT, 3'b100, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        fd(RT, 3'b001, 0, 0, IM_I, 0);
        add(RT, 3'b001, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, IM_I, 0));
        add(RT, 3'b001, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        // I-type addi with bit30 set (stays add), slti, ori
        fd(IT, 3'b000, 1, 0, IM_I, 0);
        add(IT, 3'b000, 1, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_I, 0));
        add(IT, 3'b000, 1, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        fd(IT, 3'b010, 0, 0, IM_I, 0);
        add(IT, 3'b010, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, IM_I, 0));
        add(IT, 3'b010, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        fd(IT, 3'b110, 0, 0, IM_I, 0);
        add(IT, 3'b110, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, IM_I, 0));
        add(IT, 3'b110, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        // lui
        fd(LU, 3'b000, 0, 0, IM_U, 0);
        add(LU, 3'b000, 0, 0, o(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, IM_U, 0));
        // jalr: JALRADR JAL ALUWB
        fd(JR, 3'b000, 0, 0, IM_I, 0);
        add(JR, 3'b000, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_I, 0));
        add(JR, 3'b000, 0, 0, o(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, IM_I, 0));
        add(JR, 3'b000, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0));
        // auipc straight to ALUWB
        fd(AU, 3'b000, 0, 0, IM_U, 0);
        add(AU, 3'b000, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_U, 0));
        // jal
        fd(JL, 3'b000, 0, 0, IM_J, 0);
        add(JL, 3'b000, 0, 0, o(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, IM_J, 0));
        add(JL, 3'b000, 0, 0, o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, IM_J, 0));
        // sw
        fd(SW, 3'b010, 0, 0, IM_S, 0);
        add(SW, 3'b010, 0, 0, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_S, 0));
        add(SW, 3'b010, 0, 0, o(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, IM_S, 0));
        // illegal: DECODE flags it, then back to FETCH
        fd(BAD, 3'b000, 0, 0, IM_I, 1);
        fd(LW, 3'b010, 0, 0, IM_I, 0);

        reset_n = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply("in_reset", mkv(LW, o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, IM_I, 0)));
        reset_n = 1'b1;

        // Previous apply left us on a negedge with the DUT in FETCH.
        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("row%0d", i), vecs[i]);

        // The final table row was DECODE of lw: run MEMADR, MEMREAD, then reset during MEMWB.
        apply("lw_memadr", mkv(LW, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_I, 0)));
        apply("lw_memread", mkv(LW, o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, IM_I, 0)));
        reset_n = 1'b0;
        apply("rst_in_memwb", mkv(LW, o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, IM_I, 0)));
        reset_n = 1'b1;
        apply("after_rst_fetch", mkv(SW, o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, IM_S, 0)));

        // sw interrupted by reset during MEMWRITE
        apply("sw_decode", mkv(SW, o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, IM_S, 0)));
        apply("sw_memadr", mkv(SW, o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, IM_S, 0)));
        reset_n = 1'b0;
        apply("rst_in_memwrite", mkv(SW, o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, IM_S, 0)));
        reset_n = 1'b1;
        apply("sw_rst_fetch", mkv(SW, o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, IM_S, 0)));
        apply("sw_rst_decode", mkv(SW, o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, IM_S, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
